fib_stream_gen: RTL
===================

FIB_STREAM_GEN -- requirements
Module: fib_stream_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the term width in bits.
REQ-002 SHALL have parameter CNT_W, default 6, the width of the term index and request count.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port list:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- go  input  1  start request, sampled only in IDLE.
- n  input  CNT_W  index of the last term to emit, latched on an accepted go.
- abort  input  1  cancels a sequence in progress.
- out_valid  output  1  out_data/out_idx hold a valid term.
- out_ready  input  1  sink accepts the term.
- out_data  output  DATA_W  Fibonacci term F(out_idx).
- out_idx  output  CNT_W  index of the presented term.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse on normal completion.
- ovf  output  1  sticky overflow flag.

Function
REQ-005 SHALL implement exactly three states: IDLE, RUN and DONE.
REQ-006 IDLE with go=1 at a clock edge SHALL latch n, load a=0 and b=1, clear ovf and enter RUN; out_valid SHALL be 1 in the first RUN cycle with out_data=0 and out_idx=0.
REQ-007 Sequence definition: F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2); the block SHALL emit F(0) through F(n) inclusive, i.e. n+1 terms.
REQ-008 A term SHALL transfer only on a cycle with out_valid and out_ready both 1.
REQ-009 While out_valid=1 and out_ready=0, out_data and out_idx SHALL hold stable.
REQ-010 On each transfer where out_idx is not equal to the latched n, the block SHALL advance to the next term in the following cycle; out_valid SHALL stay 1, giving a throughput of one term per cycle.
REQ-011 On transfer of the term with out_idx equal to the latched n, the block SHALL enter DONE; in DONE, done=1 and out_valid=0 for exactly one cycle, then the block SHALL return to IDLE.
REQ-012 n=0 SHALL emit the single term 0 and then complete.
REQ-013 go outside IDLE SHALL be ignored; go in the IDLE cycle immediately after DONE SHALL be accepted.
REQ-014 abort=1 in RUN or DONE SHALL force IDLE at the next edge, with no done pulse and ovf left unchanged.
REQ-015 abort SHALL take priority over a simultaneous transfer; abort in IDLE has no effect.
REQ-016 Addition SHALL be DATA_W+1 bits wide; the carry-out defines overflow.

Reset
REQ-017 reset=0 SHALL asynchronously force IDLE, with out_valid=0, out_data=0, out_idx=0, busy=0, done=0 and ovf=0, including when reset occurs mid-sequence.
REQ-018 After reset is released, the first go SHALL start a fresh sequence; no term from an interrupted sequence SHALL appear.

Configuration
REQ-019 Macro FIB_OVF_DETECT_EN defined: when the next term would carry out of DATA_W bits, that term SHALL NOT be emitted.
- After the transfer of the last representable term, the block SHALL set ovf=1 and enter DONE.
- ovf SHALL stay set until the next accepted go or reset.
REQ-020 Macro FIB_OVF_DETECT_EN undefined: terms SHALL wrap modulo 2^DATA_W, every requested term SHALL be emitted, and ovf SHALL be constant 0.

Structure
REQ-021 Package fib_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the default parameter constants.
REQ-022 Sub-module fib_datapath SHALL hold the a/b term registers, the adder with carry-out and the index counter.
- Its load/advance controls come from the FSM in fib_stream_gen.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- DATA_W=32, n=10, out_ready=1 -> out_data 0,1,1,2,3,5,8,13,21,34,55 on consecutive cycles; done pulses the cycle after 55 transfers; busy low the cycle after that.
- n=0 -> a single term 0 with out_idx 0, followed by a one-cycle done.
- n=5, out_ready toggling 1,0,0,1,... -> the value held during stalls; sequence 0,1,1,2,3,5 with no duplicates or drops.
- n=20, abort asserted on the transfer of term 4 -> term 4 not counted, no done pulse, IDLE the next cycle; a subsequent go restarts at 0.
- DATA_W=8, n=20, FIB_OVF_DETECT_EN defined -> last term 233 (idx 13), then ovf=1 and done; macro undefined -> term 14 = 121 (377 mod 256), ovf=0.
- reset pulsed low mid-RUN with n=10 -> all outputs 0 immediately; the next go emits from 0.

Source files
------------

// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and default sizes for the Fibonacci stream generator
package fib_pkg;

  localparam int FIB_DATA_W_DEF = 32;
  localparam int FIB_CNT_W_DEF  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_e;

endpackage

// File: rtl/fib_datapath.sv
// rtl/fib_datapath.sv - term registers, carry-out adder and term index counter
// a_q is the presented term F(idx_q), b_q is F(idx_q+1); carry_q flags that b_q overflowed.
module fib_datapath
  import fib_pkg::*;
#(
  parameter int DATA_W = FIB_DATA_W_DEF,
  parameter int CNT_W  = FIB_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [DATA_W-1:0] term_o,
  output logic [CNT_W-1:0]  idx_o,
  output logic              next_carry_o
);

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [DATA_W:0]   sum;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    if (load_i) begin
      a_d     = '0;
      b_d     = DATA_W'(1);
      idx_d   = '0;
      carry_d = 1'b0;
    end else if (adv_i) begin
      a_d     = b_q;
      b_d     = sum[DATA_W-1:0];
      idx_d   = idx_q + CNT_W'(1);
      carry_d = sum[DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
    end
  end

  assign term_o       = a_q;
  assign idx_o        = idx_q;
  assign next_carry_o = carry_q;

endmodule

// File: rtl/fib_stream_gen.sv
// rtl/fib_stream_gen.sv - streams F(0)..F(n) with valid/ready handshake
// FIB_OVF_DETECT_EN: stop before the first term that does not fit DATA_W and raise sticky ovf.
module fib_stream_gen
  import fib_pkg::*;
#(
  parameter int DATA_W = FIB_DATA_W_DEF,
  parameter int CNT_W  = FIB_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [CNT_W-1:0]  n,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_idx,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  fib_state_e       state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             load;
  logic             adv;
  logic             xfer;
  logic             last_term;
  logic             next_carry;
  logic             ovf_stop;

  fib_datapath #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_datapath (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load),
    .adv_i        (adv),
    .term_o       (out_data),
    .idx_o        (out_idx),
    .next_carry_o (next_carry)
  );

  assign xfer      = (state_q == RUN) && out_ready;
  assign last_term = (out_idx == n_q);

`ifdef FIB_OVF_DETECT_EN
  logic ovf_q, ovf_d;
  logic set_ovf;

  assign ovf_stop = next_carry;
  assign ovf_d    = load ? 1'b0 : (set_ovf ? 1'b1 : ovf_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_carry;

  assign unused_carry = next_carry;
  assign ovf_stop     = 1'b0;
  assign ovf          = 1'b0;
`endif

  assign n_d = load ? n : n_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  // abort outranks a transfer in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (go) state_d = RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (xfer && (last_term || ovf_stop)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == RUN);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE) && !abort;
    load      = (state_q == IDLE) && go;
    adv       = xfer && !abort && !last_term && !ovf_stop;
`ifdef FIB_OVF_DETECT_EN
    set_ovf   = xfer && !abort && !last_term && ovf_stop;
`endif
  end

endmodule
